write_result_checker: RTL

Parametrised on-chip result checker for the pipelined MIPS test environment. It snoops the data-memory write port (addr/data/wen), compares each result write against a run-time-loadable answer table, and counts errors. It also counts run duration and reports finish/pass/timeout. It replaces fixed-answer, fixed-length checkers: check count, base address, widths and timeout are parameters, answers are loaded through a port, and out-of-order, duplicate and missing writes are detected.

---
 rtl/write_result_checker.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/write_result_checker.sv
// Snoops data-memory writes, checks them in order against a loadable answer table, counts errors and run cycles.
// Latency: every output updates on the edge that samples the triggering write (1 cycle); outputs are registered.
// Backpressure: none, passive snoop; a write held across stalls counts once, on its rising wen.
module write_result_checker #(
    parameter int unsigned       ADDR_W     = 30,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       NUM_CHECKS = 14,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int unsigned       CNT_W      = 16,
    parameter int unsigned       TIMEOUT    = 16'hFFFF,
    localparam int unsigned      IDX_W      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_idx,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              wen,
    output logic [7:0]        error_num,
    output logic [CNT_W-1:0]  duration,
    output logic              finish,
    output logic              pass,
    output logic              timeout,
    output logic [IDX_W-1:0]  first_err_idx
);

    typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

    localparam logic [IDX_W:0]   NC = (IDX_W+1)'(NUM_CHECKS);
    localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

    state_t              state, state_nxt;
    logic                wen_q;
    logic [IDX_W:0]      ptr, ptr_nxt;
    logic [7:0]          err_nxt;
    logic [CNT_W-1:0]    dur_nxt, dur_inc;
    logic                to_nxt;
    logic [IDX_W-1:0]    fei_nxt;
    logic [DATA_W-1:0]   ans [NUM_CHECKS];

    logic [ADDR_W-1:0]   off;
    logic [IDX_W-1:0]    idx;
    logic                hit;
    logic                err_hit;
    logic [6:0]          miss;
    logic [6:0]          add;
    logic [9:0]          sum;

    assign off     = addr - BASE_ADDR;
    assign idx     = off[IDX_W-1:0];
    // The explicit lower bound guards against wrap-around when addr < BASE_ADDR.
    assign hit     = wen && !wen_q && (addr >= BASE_ADDR) && (off < ADDR_W'(NUM_CHECKS));
    assign dur_inc = (duration == '1) ? duration : duration + 1'b1;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        dur_nxt   = duration;
        to_nxt    = timeout;
        fei_nxt   = first_err_idx;
        err_hit   = 1'b0;
        miss      = '0;
        case (state)
            IDLE: begin
                if (hit && idx == '0) begin
                    err_hit   = (data != ans[0]);
                    ptr_nxt   = (IDX_W+1)'(1);
                    dur_nxt   = '0;
                    state_nxt = (NUM_CHECKS == 1) ? REPORT : CHECK;
                end
            end
            CHECK: begin
                if (hit) begin
                    err_hit = ({1'b0, idx} != ptr) || (data != ans[idx]);
                    ptr_nxt = {1'b0, idx} + 1'b1;
                end
                if (hit && ptr_nxt == NC) begin
                    state_nxt = REPORT;
                    dur_nxt   = dur_inc;
                end else if (duration == TO) begin
                    // Every index not yet written counts as a missing-write error.
                    state_nxt = REPORT;
                    to_nxt    = 1'b1;
                    miss      = 7'(NC - ptr_nxt);
                end else begin
                    dur_nxt   = dur_inc;
                end
            end
            default: ;
        endcase

        add     = miss + {6'b0, err_hit};
        sum     = {2'b0, error_num} + {3'b0, add};
        err_nxt = (sum > 10'd255) ? 8'hFF : sum[7:0];
        if (error_num == 8'd0 && add != 7'd0)
            fei_nxt = err_hit ? idx : ptr_nxt[IDX_W-1:0];

        if (clr) begin
            state_nxt = IDLE;
            ptr_nxt   = '0;
            err_nxt   = '0;
            dur_nxt   = '0;
            to_nxt    = 1'b0;
            fei_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            wen_q         <= 1'b0;
            ptr           <= '0;
            error_num     <= '0;
            duration      <= '0;
            timeout       <= 1'b0;
            first_err_idx <= '0;
        end else begin
            state         <= state_nxt;
            wen_q         <= wen;
            ptr           <= ptr_nxt;
            error_num     <= err_nxt;
            duration      <= dur_nxt;
            timeout       <= to_nxt;
            first_err_idx <= fei_nxt;
        end
    end

    // A load coincident with the start write lands after the compare reads ans[0].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_CHECKS); i++)
                ans[i] <= '0;
        end else if (state == IDLE && !clr && ld_en && ({1'b0, ld_idx} < NC)) begin
            ans[ld_idx] <= ld_data;
        end
    end

    assign finish = (state == REPORT);
    assign pass   = finish && (error_num == 8'd0) && !timeout;

endmodule
